// File: rtl/enc_ctrl_pkg.sv
// Shared types for the encoder parameter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ui_state_t (controller FSM states), rotation-direction encodings.
package enc_ctrl_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } ui_state_t;

  // Value of enc_clockwise / detent_cw for each rotation direction.
  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/enc_event_decoder.sv
// Turns encoder levels into single-cycle detent/press events plus an accel step.
// Latency: 1 cycle from input edge to registered event strobe.
// Backpressure: none; every event is a one-cycle pulse the consumer must take or lose.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   enc_click, enc_clockwise, enc_switch raw debounced encoder levels (switch active-low)
//   detent_stb, detent_cw               one detent and its direction
//   press_stb                           switch press (wins over a same-cycle detent)
//   step                                step size attached to the current detent
module enc_event_decoder #(
  parameter int PARAM_W      = 8,
  parameter int ACCEL_STEP   = 4,
  parameter int ACCEL_WINDOW = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_click,
  input  logic               enc_clockwise,
  input  logic               enc_switch,
  output logic               detent_stb,
  output logic               detent_cw,
  output logic               press_stb,
  output logic [PARAM_W-1:0] step
);

  localparam int AW = $clog2(ACCEL_WINDOW + 1);
  localparam logic [AW-1:0] ACC_SAT = AW'(ACCEL_WINDOW);

  logic          enc_click_dly;
  logic          enc_switch_dly;
  logic          armed;
  logic [AW-1:0] accel_cnt;
  logic          detent_raw;
  logic          press_raw;

  // The delay registers come out of reset at idle levels, but an input held
  // active through reset would still look like an edge on the first cycle.
  // 'armed' masks that first cycle so the delay registers can load the real
  // input levels before any edge is believed.
  assign detent_raw = armed & enc_click & ~enc_click_dly;
  assign press_raw  = armed & ~enc_switch & enc_switch_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_click_dly  <= 1'b1;
      enc_switch_dly <= 1'b1;
      armed          <= 1'b0;
      accel_cnt      <= ACC_SAT;
      detent_stb     <= 1'b0;
      detent_cw      <= 1'b0;
      press_stb      <= 1'b0;
      step           <= PARAM_W'(1);
    end else begin
      armed          <= 1'b1;
      enc_click_dly  <= enc_click;
      enc_switch_dly <= enc_switch;
      press_stb      <= press_raw;
      // Press has priority: a detent in the same cycle is discarded.
      detent_stb     <= detent_raw & ~press_raw;
      detent_cw      <= enc_clockwise;
      // accel_cnt counts cycles since the previous detent edge; a dropped
      // detent still restarts the window since the encoder did rotate.
      if (detent_raw) begin
        accel_cnt <= '0;
        step      <= (accel_cnt < ACC_SAT) ? PARAM_W'(ACCEL_STEP) : PARAM_W'(1);
      end else if (accel_cnt != ACC_SAT) begin
        accel_cnt <= accel_cnt + AW'(1);
      end
    end
  end

endmodule

// File: rtl/enc_param_ctrl.sv
// Rotary-encoder UI: browse/select a parameter, edit a shadow copy, commit on press.
// Latency: 2 cycles input edge to state/value change; commit visible 1 cycle after COMMIT.
// Backpressure: none; strobes are single-cycle pulses with no handshake.
// Ports:
//   clk, reset                             clock, synchronous active-high reset
//   enc_click, enc_clockwise, enc_switch   encoder levels (switch active-low)
//   param_sel                              selected parameter index
//   edit_mode                              high while editing
//   edit_value                             shadow value (mirrors committed value outside EDIT)
//   param_bank                             committed values, entry i at [i*PARAM_W +: PARAM_W]
//   update_stb, update_idx                 commit pulse and the index written
//   abort_stb                              inactivity-timeout pulse
module enc_param_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int NUM_PARAMS     = 4,
  parameter int PARAM_W        = 8,
  parameter int DEFAULT_VALUE  = 128,
  parameter int MAX_VALUE      = 255,
  parameter int ACCEL_STEP     = 4,
  parameter int ACCEL_WINDOW   = 2000000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enc_click,
  input  logic                          enc_clockwise,
  input  logic                          enc_switch,
  output logic [$clog2(NUM_PARAMS)-1:0] param_sel,
  output logic                          edit_mode,
  output logic [PARAM_W-1:0]            edit_value,
  output logic [NUM_PARAMS*PARAM_W-1:0] param_bank,
  output logic                          update_stb,
  output logic [$clog2(NUM_PARAMS)-1:0] update_idx,
  output logic                          abort_stb
);

  localparam int SEL_W = $clog2(NUM_PARAMS);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_PARAMS - 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PARAM_W-1:0] DEF_VAL  = PARAM_W'(DEFAULT_VALUE);
  localparam logic [PARAM_W:0]   MAX_EXT  = (PARAM_W + 1)'(MAX_VALUE);

  ui_state_t state, state_nxt;

  logic               detent_stb;
  logic               detent_cw;
  logic               press_stb;
  logic [PARAM_W-1:0] step;

  logic [PARAM_W-1:0] bank_q [NUM_PARAMS];
  logic [PARAM_W-1:0] cur_val;
  logic [TW-1:0]      tmo_cnt;
  logic               tmo_hit;
  logic               do_commit;
  logic               do_abort;

  logic [PARAM_W:0]   sum_ext;
  logic [PARAM_W-1:0] inc_val;
  logic [PARAM_W-1:0] dec_val;

  enc_event_decoder #(
    .PARAM_W      (PARAM_W),
    .ACCEL_STEP   (ACCEL_STEP),
    .ACCEL_WINDOW (ACCEL_WINDOW)
  ) u_dec (
    .clk           (clk),
    .reset         (reset),
    .enc_click     (enc_click),
    .enc_clockwise (enc_clockwise),
    .enc_switch    (enc_switch),
    .detent_stb    (detent_stb),
    .detent_cw     (detent_cw),
    .press_stb     (press_stb),
    .step          (step)
  );

  assign cur_val = bank_q[param_sel];
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Saturating adjust; the add uses one extra bit so it cannot wrap.
  assign sum_ext = {1'b0, edit_value} + {1'b0, step};
  assign inc_val = (sum_ext > MAX_EXT) ? MAX_EXT[PARAM_W-1:0] : sum_ext[PARAM_W-1:0];
  assign dec_val = (edit_value < step) ? '0 : (edit_value - step);

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bank
    assign param_bank[g*PARAM_W +: PARAM_W] = bank_q[g];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BROWSE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a detent in the timeout cycle counts as activity.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BROWSE: if (press_stb) state_nxt = EDIT;
      EDIT: begin
        if (press_stb) begin
          state_nxt = COMMIT;
        end else if (!detent_stb && tmo_hit) begin
          state_nxt = BROWSE;
        end
      end
      COMMIT:  state_nxt = BROWSE;
      default: state_nxt = BROWSE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    edit_mode = 1'b0;
    do_commit = 1'b0;
    do_abort  = 1'b0;
    unique case (state)
      EDIT: begin
        edit_mode = 1'b1;
        do_abort  = !press_stb && !detent_stb && tmo_hit;
      end
      COMMIT:  do_commit = 1'b1;
      default: ;
    endcase
  end

  // Bank, selection, shadow value, timeout counter and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) bank_q[i] <= DEF_VAL;
      param_sel  <= '0;
      edit_value <= DEF_VAL;
      tmo_cnt    <= '0;
      update_stb <= 1'b0;
      update_idx <= '0;
      abort_stb  <= 1'b0;
    end else begin
      update_stb <= do_commit;
      abort_stb  <= do_abort;

      if (do_commit) begin
        bank_q[param_sel] <= edit_value;
        update_idx        <= param_sel;
      end

      if (state == BROWSE && detent_stb) begin
        if (detent_cw == DIR_CW) begin
          param_sel <= (param_sel == LAST_SEL) ? '0 : param_sel + SEL_W'(1);
        end else begin
          param_sel <= (param_sel == '0) ? LAST_SEL : param_sel - SEL_W'(1);
        end
      end

      if (state == EDIT) begin
        if (detent_stb) begin
          edit_value <= (detent_cw == DIR_CW) ? inc_val : dec_val;
          tmo_cnt    <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
        if (do_abort) edit_value <= cur_val;
      end else if (state == BROWSE) begin
        // Tracking the bank here also preloads the shadow on entry to EDIT.
        edit_value <= cur_val;
        tmo_cnt    <= '0;
      end
      // COMMIT holds edit_value: it already equals the value being written.
    end
  end

endmodule

// File: tb/tb_enc_param_ctrl.sv
module tb_enc_param_ctrl;

  localparam int NP   = 4;
  localparam int PW   = 8;
  localparam int AWIN = 100;
  localparam int TMO  = 1000;
  localparam int MAXV = 255;
  localparam int DEFV = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            enc_click;
  logic            enc_clockwise;
  logic            enc_switch;
  logic [1:0]      param_sel;
  logic            edit_mode;
  logic [PW-1:0]   edit_value;
  logic [NP*PW-1:0] param_bank;
  logic            update_stb;
  logic [1:0]      update_idx;
  logic            abort_stb;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int abort_cnt = 0;
  int upd_idx_seen = 0;
  logic [NP*PW-1:0] bank_at_upd;

  // Reference model: user-visible state kept as plain integers.
  int m_bank [NP];
  int m_sel;
  bit m_edit;
  int m_val;
  int m_last;
  bit m_have_last;

  enc_param_ctrl #(
    .NUM_PARAMS     (NP),
    .PARAM_W        (PW),
    .DEFAULT_VALUE  (DEFV),
    .MAX_VALUE      (MAXV),
    .ACCEL_STEP     (4),
    .ACCEL_WINDOW   (AWIN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enc_click     (enc_click),
    .enc_clockwise (enc_clockwise),
    .enc_switch    (enc_switch),
    .param_sel     (param_sel),
    .edit_mode     (edit_mode),
    .edit_value    (edit_value),
    .param_bank    (param_bank),
    .update_stb    (update_stb),
    .update_idx    (update_idx),
    .abort_stb     (abort_stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (update_stb) begin
      upd_cnt++;
      upd_idx_seen = int'(update_idx);
      bank_at_upd  = param_bank;
    end
    if (abort_stb) abort_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_bank[i] = DEFV;
    m_sel = 0;
    m_edit = 0;
    m_val = DEFV;
    m_have_last = 0;
    m_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One detent; the model derives the step from the gap since the last detent.
  task automatic do_detent(input bit cw);
    int gap, stp;
    @(negedge clk);
    gap = cyc - m_last;
    stp = (m_have_last && (gap - 1) < AWIN) ? 4 : 1;
    m_last = cyc;
    m_have_last = 1;
    if (!m_edit) begin
      m_sel = cw ? (m_sel + 1) % NP : (m_sel + NP - 1) % NP;
    end else if (cw) begin
      m_val = (m_val + stp > MAXV) ? MAXV : m_val + stp;
    end else begin
      m_val = (m_val < stp) ? 0 : m_val - stp;
    end
    enc_clockwise = cw;
    enc_click = 1'b1;
    @(negedge clk);
    enc_click = 1'b0;
  endtask

  task automatic do_press();
    @(negedge clk);
    if (!m_edit) begin
      m_edit = 1;
      m_val = m_bank[m_sel];
    end else begin
      m_bank[m_sel] = m_val;
      m_edit = 0;
    end
    enc_switch = 1'b0;
    @(negedge clk);
    enc_switch = 1'b1;
  endtask

  task automatic test_reset();
    enc_click = 1'b0;
    enc_clockwise = 1'b0;
    enc_switch = 1'b1;
    reset = 1'b1;
    idle(4);
    reset = 1'b0;
    model_reset();
    idle(2);
    vectors++; if (param_sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel: got %0d expected 0", param_sel); end
    vectors++; if (edit_mode !== 1'b0) begin miscompares++; $display("FAIL reset_mode: got %0d expected 0", edit_mode); end
    vectors++; if (edit_value !== 8'(DEFV)) begin miscompares++; $display("FAIL reset_value: got %0d expected %0d", edit_value, DEFV); end
    vectors++; if (update_stb !== 1'b0 || abort_stb !== 1'b0 || update_idx !== 2'd0) begin
      miscompares++; $display("FAIL reset_strobes: got upd=%0d abort=%0d idx=%0d expected 0 0 0", update_stb, abort_stb, update_idx);
    end
    for (int i = 0; i < NP; i++) begin
      vectors++; if (param_bank[i*PW +: PW] !== 8'(DEFV)) begin miscompares++; $display("FAIL reset_bank[%0d]: got %0d expected %0d", i, param_bank[i*PW +: PW], DEFV); end
    end
  endtask

  task automatic test_browse_wrap();
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      do_detent(1'b1);
      idle(198);
      vectors++; if (param_sel !== 2'((i + 1) % NP)) begin miscompares++; $display("FAIL browse_sel[%0d]: got %0d expected %0d", i, param_sel, (i + 1) % NP); end
    end
    vectors++; if (edit_mode !== 1'b0) begin miscompares++; $display("FAIL browse_mode: got %0d expected 0", edit_mode); end
    vectors++; if (upd_cnt != 0) begin miscompares++; $display("FAIL browse_no_update: got %0d pulses expected 0", upd_cnt); end
  endtask

  task automatic test_commit();
    do_press();
    idle(20);
    vectors++; if (edit_mode !== 1'b1) begin miscompares++; $display("FAIL commit_enter: got %0d expected 1", edit_mode); end
    vectors++; if (edit_value !== 8'(DEFV)) begin miscompares++; $display("FAIL commit_preload: got %0d expected %0d", edit_value, DEFV); end
    for (int i = 0; i < 3; i++) begin
      do_detent(1'b1);
      idle(198);
    end
    vectors++; if (edit_value !== 8'd131) begin miscompares++; $display("FAIL commit_edit: got %0d expected 131", edit_value); end
    upd_cnt = 0;
    do_press();
    idle(20);
    vectors++; if (upd_cnt != 1 || upd_idx_seen != 1) begin miscompares++; $display("FAIL commit_stb: got %0d pulses idx %0d expected 1 pulse idx 1", upd_cnt, upd_idx_seen); end
    vectors++; if (bank_at_upd[PW +: PW] !== 8'd131) begin miscompares++; $display("FAIL commit_bank_with_stb: got %0d expected 131", bank_at_upd[PW +: PW]); end
    for (int i = 0; i < NP; i++) begin
      vectors++; if (param_bank[i*PW +: PW] !== ((i == 1) ? 8'd131 : 8'(DEFV))) begin
        miscompares++; $display("FAIL commit_bank[%0d]: got %0d expected %0d", i, param_bank[i*PW +: PW], (i == 1) ? 131 : DEFV);
      end
    end
    vectors++; if (edit_mode !== 1'b0 || edit_value !== 8'd131) begin miscompares++; $display("FAIL commit_exit: got mode %0d value %0d expected 0 131", edit_mode, edit_value); end
  endtask

  task automatic test_saturation();
    do_detent(1'b0);
    idle(198);
    vectors++; if (param_sel !== 2'd0) begin miscompares++; $display("FAIL sat_sel: got %0d expected 0", param_sel); end
    do_press();
    idle(200);
    for (int i = 0; i < 40; i++) begin
      do_detent(1'b0);
      idle(48);
      vectors++; if (edit_value !== 8'(m_val)) begin miscompares++; $display("FAIL sat_down[%0d]: got %0d expected %0d", i, edit_value, m_val); end
      if (i == 0) begin
        vectors++; if (edit_value !== 8'd127) begin miscompares++; $display("FAIL sat_first_step: got %0d expected 127", edit_value); end
      end
      if (i == 1) begin
        vectors++; if (edit_value !== 8'd123) begin miscompares++; $display("FAIL sat_accel_step: got %0d expected 123", edit_value); end
      end
    end
    vectors++; if (edit_value !== 8'd0) begin miscompares++; $display("FAIL sat_floor: got %0d expected 0", edit_value); end
    idle(200);
    do_detent(1'b1);
    idle(48);
    for (int i = 0; i < 63; i++) begin
      do_detent(1'b1);
      idle(48);
    end
    vectors++; if (edit_value !== 8'd253) begin miscompares++; $display("FAIL sat_253: got %0d expected 253", edit_value); end
    do_detent(1'b1);
    idle(48);
    vectors++; if (edit_value !== 8'd255) begin miscompares++; $display("FAIL sat_ceiling: got %0d expected 255", edit_value); end
    do_detent(1'b1);
    idle(48);
    vectors++; if (edit_value !== 8'd255) begin miscompares++; $display("FAIL sat_hold_max: got %0d expected 255", edit_value); end
    upd_cnt = 0;
    do_press();
    idle(20);
    vectors++; if (param_bank[0 +: PW] !== 8'd255 || upd_cnt != 1 || upd_idx_seen != 0) begin
      miscompares++; $display("FAIL sat_commit: got bank0 %0d pulses %0d idx %0d expected 255 1 0", param_bank[0 +: PW], upd_cnt, upd_idx_seen);
    end
  endtask

  task automatic test_timeout();
    do_detent(1'b1);
    idle(198);
    do_detent(1'b1);
    idle(198);
    vectors++; if (param_sel !== 2'd2) begin miscompares++; $display("FAIL tmo_sel: got %0d expected 2", param_sel); end
    abort_cnt = 0;
    do_press();
    idle(200);
    do_detent(1'b1);
    idle(20);
    vectors++; if (edit_value !== 8'd129) begin miscompares++; $display("FAIL tmo_edit: got %0d expected 129", edit_value); end
    idle(880);
    vectors++; if (edit_mode !== 1'b1 || abort_cnt != 0) begin miscompares++; $display("FAIL tmo_early: got mode %0d aborts %0d expected 1 0", edit_mode, abort_cnt); end
    idle(200);
    m_edit = 0;
    vectors++; if (abort_cnt != 1) begin miscompares++; $display("FAIL tmo_abort_stb: got %0d pulses expected 1", abort_cnt); end
    vectors++; if (edit_mode !== 1'b0) begin miscompares++; $display("FAIL tmo_exit: got %0d expected 0", edit_mode); end
    vectors++; if (edit_value !== 8'(DEFV) || param_bank[2*PW +: PW] !== 8'(DEFV)) begin
      miscompares++; $display("FAIL tmo_discard: got value %0d bank2 %0d expected %0d %0d", edit_value, param_bank[2*PW +: PW], DEFV, DEFV);
    end
  endtask

  task automatic test_press_priority();
    @(negedge clk);
    m_last = cyc;
    m_have_last = 1;
    m_edit = 1;
    m_val = m_bank[m_sel];
    enc_clockwise = 1'b1;
    enc_click = 1'b1;
    enc_switch = 1'b0;
    @(negedge clk);
    enc_click = 1'b0;
    enc_switch = 1'b1;
    idle(20);
    vectors++; if (edit_mode !== 1'b1) begin miscompares++; $display("FAIL prio_edit: got %0d expected 1", edit_mode); end
    vectors++; if (param_sel !== 2'd2) begin miscompares++; $display("FAIL prio_sel: got %0d expected 2", param_sel); end
    vectors++; if (edit_value !== 8'(DEFV)) begin miscompares++; $display("FAIL prio_value: got %0d expected %0d", edit_value, DEFV); end
  endtask

  task automatic test_reset_mid_edit();
    idle(200);
    do_detent(1'b1);
    idle(198);
    do_detent(1'b1);
    idle(198);
    vectors++; if (edit_value !== 8'd130) begin miscompares++; $display("FAIL rst_pre: got %0d expected 130", edit_value); end
    upd_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    enc_switch = 1'b0;
    idle(3);
    reset = 1'b0;
    model_reset();
    idle(20);
    vectors++; if (edit_mode !== 1'b0 || param_sel !== 2'd0) begin miscompares++; $display("FAIL rst_state: got mode %0d sel %0d expected 0 0", edit_mode, param_sel); end
    vectors++; if (edit_value !== 8'(DEFV) || upd_cnt != 0) begin miscompares++; $display("FAIL rst_value: got %0d pulses %0d expected %0d 0", edit_value, upd_cnt, DEFV); end
    for (int i = 0; i < NP; i++) begin
      vectors++; if (param_bank[i*PW +: PW] !== 8'(DEFV)) begin miscompares++; $display("FAIL rst_bank[%0d]: got %0d expected %0d", i, param_bank[i*PW +: PW], DEFV); end
    end
    enc_switch = 1'b1;
    idle(10);
    vectors++; if (edit_mode !== 1'b0) begin miscompares++; $display("FAIL rst_no_press: got %0d expected 0", edit_mode); end
  endtask

  task automatic test_random();
    int op, gap, prev_upd;
    bit was_edit;
    int exp_ev;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4);
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(20, 70) : $urandom_range(150, 300);
      prev_upd = upd_cnt;
      was_edit = m_edit;
      if (op == 4) do_press();
      else do_detent(op % 2 == 1);
      idle(gap);
      exp_ev = m_edit ? m_val : m_bank[m_sel];
      vectors++; if (param_sel !== 2'(m_sel)) begin miscompares++; $display("FAIL rand_sel[%0d]: got %0d expected %0d", n, param_sel, m_sel); end
      vectors++; if (edit_mode !== m_edit) begin miscompares++; $display("FAIL rand_mode[%0d]: got %0d expected %0d", n, edit_mode, m_edit); end
      vectors++; if (edit_value !== 8'(exp_ev)) begin miscompares++; $display("FAIL rand_value[%0d]: got %0d expected %0d", n, edit_value, exp_ev); end
      for (int i = 0; i < NP; i++) begin
        vectors++; if (param_bank[i*PW +: PW] !== 8'(m_bank[i])) begin miscompares++; $display("FAIL rand_bank[%0d][%0d]: got %0d expected %0d", n, i, param_bank[i*PW +: PW], m_bank[i]); end
      end
      if (op == 4 && was_edit) begin
        vectors++; if (upd_cnt != prev_upd + 1 || upd_idx_seen != m_sel) begin
          miscompares++; $display("FAIL rand_update[%0d]: got %0d pulses idx %0d expected 1 idx %0d", n, upd_cnt - prev_upd, upd_idx_seen, m_sel);
        end
      end else begin
        vectors++; if (upd_cnt != prev_upd) begin miscompares++; $display("FAIL rand_no_update[%0d]: got %0d pulses expected 0", n, upd_cnt - prev_upd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_browse_wrap();
    test_commit();
    test_saturation();
    test_timeout();
    test_press_priority();
    test_reset_mid_edit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_param_ctrl.md
Name: enc_param_ctrl

Overview:
User-interface controller that turns debounced rotary-encoder outputs (detent click, direction, push switch) into a bank of user parameters (e.g. volume, balance, bass, treble).
- Browse mode: rotation selects a parameter.
- Edit mode: rotation adjusts a shadow copy of the selected parameter, with speed acceleration.
- A press commits the edit; inactivity times out and discards it.
- Sits between the encoder front end and the audio datapath/CPU register map.

Parameters:
NUM_PARAMS, 4, number of parameters in the bank (>=2)
PARAM_W, 8, width of each parameter value
DEFAULT_VALUE, 128, reset value of every parameter
MAX_VALUE, 255, upper saturation bound (lower bound fixed at 0)
ACCEL_STEP, 4, step size when detents arrive faster than ACCEL_WINDOW
ACCEL_WINDOW, 2000000, cycles; detent gap below this selects ACCEL_STEP, otherwise step 1
TIMEOUT_CYCLES, 250000000, cycles of inactivity in EDIT before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enc_click  in  1  level; high while encoder in detent state; rising edge = one detent
enc_clockwise  in  1  rotation direction, valid when enc_click rises
enc_switch  in  1  debounced switch, active-low (0 = pressed)
param_sel  out  $clog2(NUM_PARAMS)  currently selected parameter index
edit_mode  out  1  high while in EDIT
edit_value  out  PARAM_W  shadow value being edited (equals committed value of param_sel outside EDIT)
param_bank  out  NUM_PARAMS*PARAM_W  committed values, index i at [i*PARAM_W +: PARAM_W]
update_stb  out  1  one-cycle pulse on commit
update_idx  out  $clog2(NUM_PARAMS)  index committed, valid with update_stb
abort_stb  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (synchronous, active-high, any state, any cycle) sets:
  - all param_bank entries = DEFAULT_VALUE, param_sel = 0, FSM = BROWSE, edit_value = DEFAULT_VALUE;
  - update_stb = abort_stb = 0, update_idx = 0;
  - edge-detect registers to idle (enc_click_dly = 1, enc_switch_dly = 1), so no false event follows reset;
  - accel counter = ACCEL_WINDOW (saturated), timeout counter = 0.
- Event decode, registered, 1 cycle latency from input edge:
  - detent = enc_click 0->1, dir = enc_clockwise sampled in the edge cycle;
  - press = enc_switch 1->0.
- Simultaneous detent and press in the same cycle: press wins; the detent is dropped.
- Accel counter: cleared on every detent, increments otherwise, saturates at ACCEL_WINDOW.
  - Step = ACCEL_STEP if the counter < ACCEL_WINDOW when the detent arrives, else 1.
  - The first detent after reset or idle is always step 1.
- FSM states: BROWSE, EDIT, COMMIT.
- BROWSE:
  - Detent cw: param_sel+1, wrapping NUM_PARAMS-1 -> 0.
  - Detent ccw: param_sel-1, wrapping 0 -> NUM_PARAMS-1.
  - Step size is ignored; browse always moves by 1.
  - Press: edit_value <= param_bank[param_sel], timeout counter <= 0, -> EDIT.
- EDIT:
  - Detent cw: edit_value = min(edit_value+step, MAX_VALUE), computed at PARAM_W+1 bits, no wrap.
  - Detent ccw: edit_value = (edit_value < step) ? 0 : edit_value-step.
  - Each detent clears the timeout counter.
  - Press: -> COMMIT.
  - Timeout counter reaching TIMEOUT_CYCLES-1: abort_stb = 1 for one cycle, edit_value reloaded from bank, -> BROWSE. param_bank is unchanged.
  - param_sel is frozen while in EDIT.
- COMMIT (one cycle):
  - param_bank[param_sel] <= edit_value.
  - update_stb = 1 and update_idx = param_sel, both registered, so they are visible the cycle after COMMIT together with the new bank value.
  - -> BROWSE.
  - Events arriving during the COMMIT cycle are dropped.
- Outside EDIT, edit_value tracks param_bank[param_sel] (registered, 1 cycle).
- Timeout counter width = $clog2(TIMEOUT_CYCLES+1); accel counter width = $clog2(ACCEL_WINDOW+1).

Decomposition:
- Package enc_ctrl_pkg: typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} ui_state_t; step-direction constants.
- Sub-module enc_event_decoder: edge detection of click/switch, press-priority resolution, accel counter. Outputs detent_stb, detent_cw, press_stb, step[PARAM_W-1:0].
- Top: FSM, bank, saturation arithmetic, timeout.

Test Plan:
Bench uses ACCEL_WINDOW=100 and TIMEOUT_CYCLES=1000 for speed.
1. Reset, then 5 cw detents spaced 200 cycles in BROWSE -> param_sel 0,1,2,3,0,1 (final 1); no update_stb.
2. Press, 3 cw detents spaced 200 cycles, press -> edit_value 131, update_stb one cycle with update_idx=1, param_bank[1]=131, others 128.
3. In EDIT on param 0 with value 128, 40 ccw detents spaced 50 cycles -> steps 1 then 4; edit_value decrements 127,123,... and saturates at 0 with no wrap to 255. Cw from 253 with step 4 -> 255.
4. Press, 1 detent (value 129), then idle 1000 cycles -> abort_stb pulse, edit_mode=0, param_bank unchanged at 128, edit_value reads back 128.
5. Detent and press rising in the same cycle in BROWSE -> enters EDIT, param_sel unchanged.
6. Assert reset mid-EDIT after 2 detents, holding enc_switch=0 through reset -> all params 128, BROWSE, param_sel 0, no press event detected at reset release.
